// File: rtl/ctrl_pkg.sv
// Shared types and opcode constants for the RV32I multi-cycle control path.
package ctrl_pkg;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd5
  } state_t;

  // Immediate generator decodes this same encoding.
  typedef enum logic [2:0] {
    IMM_I    = 3'd0,
    IMM_S    = 3'd1,
    IMM_B    = 3'd2,
    IMM_J    = 3'd3,
    IMM_NONE = 3'd4
  } imm_sel_t;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2
  } wb_sel_t;

  typedef enum logic {
    PC_PLUS4  = 1'b0,
    PC_TARGET = 1'b1
  } pc_sel_t;

  typedef enum logic [2:0] {
    CL_R       = 3'd0,
    CL_IARITH  = 3'd1,
    CL_LOAD    = 3'd2,
    CL_STORE   = 3'd3,
    CL_BRANCH  = 3'd4,
    CL_JAL     = 3'd5,
    CL_ILLEGAL = 3'd6
  } op_class_t;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_IARITH = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

endpackage

// File: rtl/op_decode.sv
// Combinational opcode classifier: instruction class, legality and immediate format.
module op_decode
  import ctrl_pkg::*;
(
  input  logic [6:0] opcode_i,
  output op_class_t  class_o,
  output logic       legal_o,
  output imm_sel_t   imm_sel_o
);

  always_comb begin
    class_o   = CL_ILLEGAL;
    imm_sel_o = IMM_NONE;
    case (opcode_i)
      OPC_R:      class_o = CL_R;
      OPC_IARITH: begin class_o = CL_IARITH; imm_sel_o = IMM_I; end
      OPC_LOAD:   begin class_o = CL_LOAD;   imm_sel_o = IMM_I; end
      OPC_STORE:  begin class_o = CL_STORE;  imm_sel_o = IMM_S; end
      OPC_BRANCH: begin class_o = CL_BRANCH; imm_sel_o = IMM_B; end
      OPC_JAL:    begin class_o = CL_JAL;    imm_sel_o = IMM_J; end
      default:    ;
    endcase
    legal_o = (class_o != CL_ILLEGAL);
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: sequences fetch/decode/exec/mem/wb, owns the
// memory handshake, illegal-opcode trap and retired-instruction counter.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      instr,
  input  logic             mem_ready,
  input  logic             branch_taken,
  output logic             mem_req,
  output logic             mem_we,
  output logic             addr_sel,
  output logic             ir_we,
  output logic             pc_we,
  output logic             pc_sel,
  output logic             alu_src_b,
  output logic [2:0]       imm_sel,
  output logic             reg_we,
  output logic [1:0]       wb_sel,
  output logic             illegal,
  output logic [CNT_W-1:0] instret
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] instret_q, instret_d;

  op_class_t dec_class;
  logic      dec_legal;
  imm_sel_t  dec_imm;

  logic unused_instr;
  assign unused_instr = ^instr[31:7];

  op_decode u_op_decode (
    .opcode_i  (instr[6:0]),
    .class_o   (dec_class),
    .legal_o   (dec_legal),
    .imm_sel_o (dec_imm)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= FETCH;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:  if (mem_ready) state_d = DECODE;
      DECODE: state_d = dec_legal ? EXEC : TRAP;
      EXEC: begin
        case (dec_class)
          CL_LOAD, CL_STORE:  state_d = MEM;
          CL_BRANCH, CL_JAL:  state_d = FETCH;
          default:            state_d = WB;
        endcase
      end
      MEM: begin
        if (mem_ready) state_d = (dec_class == CL_LOAD) ? WB : FETCH;
      end
      WB:      state_d = FETCH;
      TRAP:    state_d = TRAP;
      default: state_d = FETCH;
    endcase
  end

  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    addr_sel  = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pc_sel    = PC_PLUS4;
    alu_src_b = 1'b0;
    imm_sel   = IMM_NONE;
    reg_we    = 1'b0;
    wb_sel    = WB_ALU;
    illegal   = 1'b0;
    if (!reset) begin
      case (state_q)
        FETCH: begin
          mem_req = 1'b1;
          ir_we   = mem_ready;
        end
        DECODE: imm_sel = dec_imm;
        EXEC: begin
          imm_sel = dec_imm;
          case (dec_class)
            CL_IARITH, CL_LOAD, CL_STORE: alu_src_b = 1'b1;
            CL_BRANCH: begin
              pc_we  = 1'b1;
              pc_sel = branch_taken;
            end
            CL_JAL: begin
              pc_we  = 1'b1;
              pc_sel = PC_TARGET;
              reg_we = 1'b1;
              wb_sel = WB_PC4;
            end
            default: ;
          endcase
        end
        MEM: begin
          mem_req  = 1'b1;
          addr_sel = 1'b1;
          mem_we   = (dec_class == CL_STORE);
          pc_we    = mem_ready && (dec_class == CL_STORE);
        end
        WB: begin
          reg_we = 1'b1;
          wb_sel = (dec_class == CL_LOAD) ? WB_MEM : WB_ALU;
          pc_we  = 1'b1;
        end
        TRAP:    illegal = 1'b1;
        default: ;
      endcase
    end
  end

  assign instret_d = pc_we ? instret_q + 1'b1 : instret_q;
  assign instret   = instret_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed self-checking bench for multicycle_ctrl; a second CNT_W=4 instance
// shares the stimulus to exercise counter wrap-around.
module tb_multicycle_ctrl;
  import ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset, mem_ready, branch_taken;
  logic [31:0] instr;

  logic        mem_req, mem_we, addr_sel, ir_we, pc_we, pc_sel, alu_src_b, reg_we, illegal;
  logic [2:0]  imm_sel;
  logic [1:0]  wb_sel;
  logic [31:0] instret;

  logic        n_mem_req, n_mem_we, n_addr_sel, n_ir_we, n_pc_we, n_pc_sel, n_alu_src_b, n_reg_we, n_illegal;
  logic [2:0]  n_imm_sel;
  logic [1:0]  n_wb_sel;
  logic [3:0]  instret4;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  multicycle_ctrl #(.CNT_W(32)) dut (
    .clk(clk), .reset(reset), .instr(instr), .mem_ready(mem_ready),
    .branch_taken(branch_taken), .mem_req(mem_req), .mem_we(mem_we),
    .addr_sel(addr_sel), .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel),
    .alu_src_b(alu_src_b), .imm_sel(imm_sel), .reg_we(reg_we),
    .wb_sel(wb_sel), .illegal(illegal), .instret(instret)
  );

  multicycle_ctrl #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .instr(instr), .mem_ready(mem_ready),
    .branch_taken(branch_taken), .mem_req(n_mem_req), .mem_we(n_mem_we),
    .addr_sel(n_addr_sel), .ir_we(n_ir_we), .pc_we(n_pc_we), .pc_sel(n_pc_sel),
    .alu_src_b(n_alu_src_b), .imm_sel(n_imm_sel), .reg_we(n_reg_we),
    .wb_sel(n_wb_sel), .illegal(n_illegal), .instret(instret4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic st(input string tag, input state_t exp);
    chk(tag, 32'(dut.state_q), 32'(exp));
  endtask

  initial begin
    reset = 1'b1; mem_ready = 1'b0; branch_taken = 1'b0; instr = '0;
    #1;
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_imm_sel", 32'(imm_sel), 4);
    chk("rst_pc_we", 32'(pc_we), 0);
    cyc();
    reset = 1'b0;
    #1;
    st("rst_state", FETCH);
    chk("rst_instret", instret, 0);

    // ADDI
    instr = 32'h00500093; mem_ready = 1'b1; #1;
    chk("addi_f_req", 32'(mem_req), 1);
    chk("addi_f_addr", 32'(addr_sel), 0);
    chk("addi_f_irwe", 32'(ir_we), 1);
    cyc(); st("addi_dec", DECODE);
    chk("addi_d_imm", 32'(imm_sel), 0);
    chk("addi_d_regwe", 32'(reg_we), 0);
    cyc(); st("addi_exec", EXEC);
    chk("addi_e_imm", 32'(imm_sel), 0);
    chk("addi_e_srcb", 32'(alu_src_b), 1);
    chk("addi_e_pcwe", 32'(pc_we), 0);
    chk("addi_e_regwe", 32'(reg_we), 0);
    cyc(); st("addi_wb", WB);
    chk("addi_wb_regwe", 32'(reg_we), 1);
    chk("addi_wb_pcwe", 32'(pc_we), 1);
    chk("addi_wb_sel", 32'(wb_sel), 0);
    chk("addi_wb_imm", 32'(imm_sel), 4);
    cyc(); st("addi_done", FETCH);
    chk("addi_instret", instret, 1);

    // LW with two memory wait cycles
    instr = 32'h0000A103; #1;
    cyc(); st("lw_dec", DECODE);
    cyc(); st("lw_exec", EXEC);
    chk("lw_e_srcb", 32'(alu_src_b), 1);
    chk("lw_e_imm", 32'(imm_sel), 0);
    mem_ready = 1'b0;
    cyc(); st("lw_mem0", MEM);
    for (int i = 0; i < 3; i++) begin
      if (i == 2) mem_ready = 1'b1;
      #1;
      chk("lw_m_req", 32'(mem_req), 1);
      chk("lw_m_addr", 32'(addr_sel), 1);
      chk("lw_m_we", 32'(mem_we), 0);
      chk("lw_m_pcwe", 32'(pc_we), 0);
      cyc();
    end
    st("lw_wb", WB);
    chk("lw_wb_sel", 32'(wb_sel), 1);
    chk("lw_wb_regwe", 32'(reg_we), 1);
    cyc(); st("lw_done", FETCH);
    chk("lw_instret", instret, 2);

    // SW
    instr = 32'h0020A223; #1;
    cyc(); chk("sw_d_imm", 32'(imm_sel), 1);
    cyc(); st("sw_exec", EXEC);
    chk("sw_e_imm", 32'(imm_sel), 1);
    chk("sw_e_regwe", 32'(reg_we), 0);
    cyc(); st("sw_mem", MEM);
    chk("sw_m_we", 32'(mem_we), 1);
    chk("sw_m_pcwe", 32'(pc_we), 1);
    chk("sw_m_pcsel", 32'(pc_sel), 0);
    chk("sw_m_regwe", 32'(reg_we), 0);
    cyc(); st("sw_done", FETCH);
    chk("sw_instret", instret, 3);

    // BEQ taken then not taken
    instr = 32'h00000463;
    for (int t = 1; t >= 0; t--) begin
      branch_taken = t[0]; #1;
      cyc(); st("beq_dec", DECODE);
      cyc(); st("beq_exec", EXEC);
      chk("beq_e_imm", 32'(imm_sel), 2);
      chk("beq_e_pcwe", 32'(pc_we), 1);
      chk("beq_e_pcsel", 32'(pc_sel), 32'(t));
      chk("beq_e_regwe", 32'(reg_we), 0);
      cyc(); st("beq_done", FETCH);
    end
    chk("beq_instret", instret, 5);
    branch_taken = 1'b0;

    // JAL
    instr = 32'h010000EF; #1;
    cyc(); cyc(); st("jal_exec", EXEC);
    chk("jal_e_imm", 32'(imm_sel), 3);
    chk("jal_e_pcwe", 32'(pc_we), 1);
    chk("jal_e_pcsel", 32'(pc_sel), 1);
    chk("jal_e_regwe", 32'(reg_we), 1);
    chk("jal_e_wbsel", 32'(wb_sel), 2);
    cyc(); st("jal_done", FETCH);
    chk("jal_instret", instret, 6);

    // Reset during a FETCH wait
    mem_ready = 1'b0; #1;
    cyc(); st("rstw_wait", FETCH);
    chk("rstw_req_before", 32'(mem_req), 1);
    reset = 1'b1; #1;
    chk("rstw_req_in_reset", 32'(mem_req), 0);
    chk("rstw_irwe_in_reset", 32'(ir_we), 0);
    cyc();
    reset = 1'b0; #1;
    st("rstw_state", FETCH);
    chk("rstw_instret", instret, 0);
    chk("rstw_instret4", 32'(instret4), 0);

    // Sixteen branches: CNT_W=4 counter reaches all-ones then wraps to 0
    instr = 32'h00000463; mem_ready = 1'b1; #1;
    for (int k = 0; k < 15; k++) begin
      cyc(); cyc(); cyc();
    end
    chk("wrap_pre4", 32'(instret4), 15);
    cyc(); cyc(); cyc();
    chk("wrap_post4", 32'(instret4), 0);
    chk("wrap_post32", instret, 16);

    // Illegal opcode: TRAP holds with all enables low
    instr = 32'h00000000; #1;
    cyc(); st("trap_dec", DECODE);
    chk("trap_d_imm", 32'(imm_sel), 4);
    cyc();
    for (int j = 0; j < 10; j++) begin
      chk("trap_illegal", 32'(illegal), 1);
      chk("trap_enables", {25'd0, mem_req, mem_we, ir_we, pc_we, reg_we, alu_src_b, addr_sel}, 0);
      chk("trap_instret", instret, 16);
      cyc();
    end
    st("trap_state", TRAP);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
